btn_cond: RTL and testbench
===========================

Name: btn_cond

Overview:
- Conditions the raw push-button inputs into the two forms the channel-control logic consumes:
  - btn_lvl: a clean debounced level, wired to the period/mode selectors' btn inputs.
  - btn_pls: a single-cycle press pulse, wired to their bto inputs.
- Adds an optional hold-to-repeat function, so holding a button steps a selector continuously.
- One independent channel per button. Sits between the board button pins and every selector/counter block.

Parameters:
- N_BTN, 4, number of buttons/channels.
- DEB_CYC, 1000000, consecutive stable synchronized samples needed to accept a level change (10 ms at 100 MHz); must be ≥2.
- HOLD_CYC, 50000000, cycles a press must be held before auto-repeat starts (0.5 s); must be ≥1.
- RPT_CYC, 10000000, auto-repeat pulse period (0.1 s); must be ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- btn_raw  in  N_BTN  asynchronous raw button pins, active-high.
- rpt_en  in  N_BTN  per-button auto-repeat enable, sampled every cycle.
- btn_lvl  out  N_BTN  debounced button level.
- btn_pls  out  N_BTN  one-cycle pulse on accepted press and on each auto-repeat.
- btn_rel  out  N_BTN  one-cycle pulse on accepted release.

Behaviour:
- Reset:
  - One clock and one reset. rst_n is synchronous and active-low: it is sampled on the rising edge of clk.
  - rst_n=0 clears all sync flops, counters and outputs to 0 and puts every FSM in IDLE.
  - Reset takes priority over everything, including mid-debounce or mid-repeat.
- Synchronizer: 2-flop synchronizer per bit, giving btn_s. All FSM decisions use btn_s only.
- Counter: one counter per channel, sized by $clog2 of max(DEB_CYC, HOLD_CYC, RPT_CYC). It is cleared on every state transition.
- Per-channel FSM, all outputs registered:
  - IDLE (lvl=0): btn_s=1 → ARM_P, cnt=0.
  - ARM_P:
    - btn_s=0 → IDLE (glitch rejected, no output).
    - Else cnt++. When cnt==DEB_CYC-1 and btn_s=1 → HELD, lvl←1, pls←1 for 1 cycle.
  - HELD (lvl=1):
    - btn_s=0 → ARM_R.
    - Else if rpt_en: cnt++. When cnt==HOLD_CYC-1 → RPT, pls←1.
    - If rpt_en=0: cnt held at 0.
  - RPT (lvl=1):
    - btn_s=0 → ARM_R.
    - rpt_en=0 → HELD.
    - Else cnt++. When cnt==RPT_CYC-1 → pls←1, cnt←0, stay in RPT.
  - ARM_R (lvl=1):
    - btn_s=1 → HELD with cnt=0; the repeat hold timer restarts.
    - Else cnt++. When cnt==DEB_CYC-1 → IDLE, lvl←0, rel←1 for 1 cycle.
- Latency, with raw input changing before clock edge E0 and staying stable:
  - btn_pls is high during the cycle after edge E0+DEB_CYC+2.
  - btn_lvl rises on that same edge.
  - Release is symmetric: btn_rel pulses and btn_lvl falls at E0+DEB_CYC+2.
- Auto-repeat timing:
  - First repeat pulse: HOLD_CYC cycles after the press pulse.
  - Subsequent repeat pulses: every RPT_CYC cycles.
- Pulse constraints:
  - btn_pls and btn_rel are never high in the same cycle for the same channel.
  - No pulse is ever wider than 1 cycle.
- Channels are fully independent; simultaneous presses on any subset each produce their own pulse in the same cycle.
- Button already held when rst_n deasserts: treated as a fresh press, so a pulse follows DEB_CYC+2 edges after the first post-reset sample.
- No counter overflow is possible; counters always clear at their terminal value.

Test Plan (DEB_CYC=4, HOLD_CYC=10, RPT_CYC=5, N_BTN=4):
- Clean press of btn_raw[0] at E0, held for 8 cycles, rpt_en=0 → btn_pls[0]=1 only during the cycle after E6; btn_lvl[0]=1 from E6; no other bit toggles.
- Glitches: btn_raw[1] high for 3 cycles, low for 1, high for 3, then low → no btn_pls, no btn_lvl change, no btn_rel.
- Hold btn_raw[2] for 40 cycles with rpt_en[2]=1, press at E0 → pulses after E6, E16, E21, E26, E31, E36. On release at E40: btn_rel[2] after E46, btn_lvl[2] falls at E46.
- Release bounce: while held, btn_raw[0] goes low for 2 cycles then high → stays HELD, no btn_rel, and the repeat timer restarts (next repeat is 10 cycles after re-entering HELD).
- Simultaneous press of all 4 buttons at E0 → btn_pls=4'b1111 in the single cycle after E6.
- Reset mid-operation: assert rst_n=0 at E20 while btn_raw[3] is held in RPT → all outputs 0 at E21. Deassert at E25 with the button still held → fresh press pulse 6 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/btn_cond.sv
// Push-button conditioner: 2-flop sync, per-channel debounce FSM, press/release pulses and hold-to-repeat.
// Latency: btn_lvl/btn_pls/btn_rel update DEB_CYC+2 edges after a stable raw change; no backpressure, pulses are fire-and-forget.
module btn_cond #(
  parameter int N_BTN    = 4,
  parameter int DEB_CYC  = 1000000,
  parameter int HOLD_CYC = 50000000,
  parameter int RPT_CYC  = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] rpt_en,
  output logic [N_BTN-1:0] btn_lvl,
  output logic [N_BTN-1:0] btn_pls,
  output logic [N_BTN-1:0] btn_rel
);

  localparam int MAX_DH  = (DEB_CYC > HOLD_CYC) ? DEB_CYC : HOLD_CYC;
  localparam int CNT_MAX = (MAX_DH > RPT_CYC) ? MAX_DH : RPT_CYC;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] DEB_TC  = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RPT_TC  = CW'(RPT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM_P = 3'd1,
    HELD  = 3'd2,
    RPT   = 3'd3,
    ARM_R = 3'd4
  } state_t;

  logic [N_BTN-1:0] sync_q, sync_d;
  logic [N_BTN-1:0] btn_s_q, btn_s_d;

  always_comb begin
    sync_d  = btn_raw;
    btn_s_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      btn_s_q <= '0;
    end else begin
      sync_q  <= sync_d;
      btn_s_q <= btn_s_d;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          pls_q, pls_d;
    logic          rel_q, rel_d;
    logic          btn_s;
    logic          rpt;

    assign btn_s = btn_s_q[i];
    assign rpt   = rpt_en[i];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        pls_q   <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        pls_q   <= pls_d;
        rel_q   <= rel_d;
      end
    end

    // Every state change clears the counter; it never runs past a terminal value.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_d = ARM_P;
            cnt_d   = '0;
          end
        end
        ARM_P: begin
          if (!btn_s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_TC) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_d = ARM_R;
            cnt_d   = '0;
          end else if (!rpt) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_TC) begin
            state_d = RPT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RPT: begin
          if (!btn_s) begin
            state_d = ARM_R;
            cnt_d   = '0;
          end else if (!rpt) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == RPT_TC) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ARM_R: begin
          if (btn_s) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == DEB_TC) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered, so they are decoded from the transition being taken.
    always_comb begin
      lvl_d = (state_d == HELD) || (state_d == RPT) || (state_d == ARM_R);
      pls_d = ((state_q == ARM_P) && (state_d == HELD)) ||
              ((state_q == HELD)  && (state_d == RPT))  ||
              ((state_q == RPT)   && btn_s && rpt && (cnt_q == RPT_TC));
      rel_d = (state_q == ARM_R) && (state_d == IDLE);
    end

    assign btn_lvl[i] = lvl_q;
    assign btn_pls[i] = pls_q;
    assign btn_rel[i] = rel_q;
  end

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond with short debounce/hold/repeat periods; edge indices are counted from each scenario's E0.
module tb_btn_cond;
  localparam int N_BTN    = 4;
  localparam int DEB_CYC  = 4;
  localparam int HOLD_CYC = 10;
  localparam int RPT_CYC  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] rpt_en;
  logic [N_BTN-1:0] btn_lvl;
  logic [N_BTN-1:0] btn_pls;
  logic [N_BTN-1:0] btn_rel;

  int checks   = 0;
  int failures = 0;
  int e;

  always #5 clk = ~clk;

  btn_cond #(
    .N_BTN   (N_BTN),
    .DEB_CYC (DEB_CYC),
    .HOLD_CYC(HOLD_CYC),
    .RPT_CYC (RPT_CYC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_raw),
    .rpt_en (rpt_en),
    .btn_lvl(btn_lvl),
    .btn_pls(btn_pls),
    .btn_rel(btn_rel)
  );

  task automatic chk(input string tag, input int k, input logic [N_BTN-1:0] obs,
                     input logic [N_BTN-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s @E%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // Advance to 1 time unit after edge Ek of the current scenario.
  task automatic go_to(input int k);
    while (e < k) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic chk_outs(input string tag, input int k, input logic [N_BTN-1:0] pls,
                          input logic [N_BTN-1:0] lvl, input logic [N_BTN-1:0] rel,
                          input bit do_pls);
    if (do_pls) chk({tag, "_pls"}, k, btn_pls, pls);
    chk({tag, "_lvl"}, k, btn_lvl, lvl);
    chk({tag, "_rel"}, k, btn_rel, rel);
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 4'b1111;
    rpt_en  = 4'b1111;
    e       = -1;
    go_to(3);
    chk_outs("reset", e, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    btn_raw = 4'b0000;
    rpt_en  = 4'b0000;
    go_to(4);
    rst_n = 1'b1;
    go_to(12);
    chk_outs("post_reset_idle", e, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Clean press of button 0 for 8 cycles, no repeat.
    e = -1;
    for (int k = 0; k <= 16; k++) begin
      btn_raw[0] = (k < 8);
      go_to(k);
      chk_outs("clean", k, (k == 6) ? 4'b0001 : 4'b0000,
               (k >= 6 && k < 14) ? 4'b0001 : 4'b0000,
               (k == 14) ? 4'b0001 : 4'b0000, 1'b1);
    end

    // Bouncy press on button 1 never lasts long enough to be accepted.
    e = -1;
    for (int k = 0; k <= 14; k++) begin
      btn_raw[1] = (k < 3) || (k >= 4 && k < 7);
      go_to(k);
      chk_outs("glitch", k, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    end

    // Hold button 2 with auto-repeat; the pulse at E41 straddles release and is left unchecked.
    rpt_en = 4'b0100;
    e = -1;
    for (int k = 0; k <= 47; k++) begin
      btn_raw[2] = (k < 40);
      go_to(k);
      chk_outs("repeat", k,
               (k inside {6, 16, 21, 26, 31, 36}) ? 4'b0100 : 4'b0000,
               (k >= 6 && k < 46) ? 4'b0100 : 4'b0000,
               (k == 46) ? 4'b0100 : 4'b0000, (k != 41));
    end
    rpt_en = 4'b0000;

    // Short release bounce on button 0 restarts the hold timer instead of releasing.
    rpt_en = 4'b0001;
    e = -1;
    for (int k = 0; k <= 37; k++) begin
      btn_raw[0] = (k < 30) && !(k == 10 || k == 11);
      go_to(k);
      chk_outs("bounce", k,
               (k inside {6, 24, 29}) ? 4'b0001 : 4'b0000,
               (k >= 6 && k < 36) ? 4'b0001 : 4'b0000,
               (k == 36) ? 4'b0001 : 4'b0000, 1'b1);
    end
    rpt_en = 4'b0000;

    // All four buttons pressed and released together.
    e = -1;
    for (int k = 0; k <= 16; k++) begin
      btn_raw = (k < 9) ? 4'b1111 : 4'b0000;
      go_to(k);
      chk_outs("simul", k, (k == 6) ? 4'b1111 : 4'b0000,
               (k >= 6 && k < 15) ? 4'b1111 : 4'b0000,
               (k == 15) ? 4'b1111 : 4'b0000, 1'b1);
    end

    // Reset while button 3 is repeating; the still-held button is a fresh press afterwards.
    rpt_en = 4'b1000;
    e = -1;
    for (int k = 0; k <= 33; k++) begin
      btn_raw[3] = 1'b1;
      rst_n      = !(k >= 20 && k < 25);
      go_to(k);
      chk_outs("rst_mid", k,
               (k == 6 || k == 16 || k == 31) ? 4'b1000 : 4'b0000,
               ((k >= 6 && k < 20) || k >= 31) ? 4'b1000 : 4'b0000,
               4'b0000, 1'b1);
    end
    btn_raw = 4'b0000;
    rpt_en  = 4'b0000;
    e = -1;
    go_to(6);
    chk_outs("rst_mid_release", e, 4'b0000, 4'b0000, 4'b1000, 1'b1);
    go_to(7);
    chk_outs("final_idle", e, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
